int_to_fp9: RTL and testbench

Sequential converter from 16-bit two's-complement integers to the lab's 9-bit floating-point format (sign, 4-bit exponent, 4-bit fraction with hidden 1). It is the front end that feeds integer operands into the floating-point add/subtract datapath. Each result is produced with a valid/ready handshake and an overflow flag, a zero flag and an inexact flag. Normalisation is iterative, one left shift per cycle.

---
 rtl/fp9_pkg.sv | 26 ++
 rtl/abs16.sv | 10 +
 rtl/int_to_fp9.sv | 128 ++++++++++++
 tb/tb_int_to_fp9.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp9_pkg.sv
// Shared definitions for the lab's 9-bit floating-point format:
// {sign, exp[3:0], frac[3:0]}, value = (-1)^s * 1.f * 2^(e-1), e = 0 reserved for zero.
package fp9_pkg;

   localparam int FP_W   = 9;
   localparam int EXP_W  = 4;
   localparam int FRAC_W = 4;
   localparam int INT_W  = 16;

   localparam logic [EXP_W-1:0] EXP_MAX = 4'hF;

   typedef struct packed {
      logic              s;
      logic [EXP_W-1:0]  e;
      logic [FRAC_W-1:0] f;
   } fp9_t;

   localparam fp9_t FP9_ZERO = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : fp9_pkg

// File: rtl/abs16.sv
// Combinational two's-complement magnitude. -32768 maps to 16'h8000, which the
// converter then reports as overflow.
module abs16 (
   input  logic [15:0] data_i,
   output logic [15:0] mag_o
);

   assign mag_o = data_i[15] ? (~data_i + 16'd1) : data_i;

endmodule : abs16

// File: rtl/int_to_fp9.sv
// Sequential 16-bit signed integer to fp9 converter with valid/ready handshake.
// Normalisation shifts the magnitude left one bit per cycle until bit 14 is set.
module int_to_fp9
   import fp9_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [INT_W-1:0]    in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [FP_W-1:0]     out_result,
   output logic                out_ov,
   output logic                out_z,
   output logic                out_inexact
);

   state_e             state_q, state_d;
   logic               sign_q, sign_d;
   logic [INT_W-1:0]   mag_q, mag_d;
   logic [EXP_W-1:0]   exp_q, exp_d;
   fp9_t               result_q, result_d;
   logic               ov_q, ov_d;
   logic               z_q, z_d;
   logic               inexact_q, inexact_d;
   logic               out_valid_q, out_valid_d;
   logic [INT_W-1:0]   abs_mag;
   logic               handshake;

   abs16 u_abs16 (
      .data_i (in_data),
      .mag_o  (abs_mag)
   );

   assign handshake = out_valid_q && out_ready;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
      state_d   = state_q;
      sign_d    = sign_q;
      mag_d     = mag_q;
      exp_d     = exp_q;
      result_d  = result_q;
      ov_d      = ov_q;
      z_d       = z_q;
      inexact_d = inexact_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d    = in_data[INT_W-1];
               mag_d     = abs_mag;
               exp_d     = EXP_MAX;
               result_d  = FP9_ZERO;
               ov_d      = 1'b0;
               z_d       = 1'b0;
               inexact_d = 1'b0;
               state_d   = CONV;
            end
         end

         CONV: begin
            if (mag_q[15]) begin
               result_d = '{s: sign_q, e: EXP_MAX, f: 4'hF};
               ov_d     = 1'b1;
               state_d  = DONE;
            end else if (mag_q == '0) begin
               result_d = FP9_ZERO;
               z_d      = 1'b1;
               state_d  = DONE;
            end else if (mag_q[14]) begin
               // Bit 14 is the hidden one; bits 13:10 become the fraction, the rest is truncated.
               result_d  = '{s: sign_q, e: exp_q, f: mag_q[13:10]};
               inexact_d = |mag_q[9:0];
               state_d   = DONE;
            end else begin
               mag_d = mag_q << 1;
               exp_d = exp_q - 4'd1;
            end
         end

         DONE: begin
            if (handshake) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // out_valid is a registered copy of DONE, so it rises one cycle after the result is latched.
   assign out_valid_d = (state_q == DONE) && !handshake;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         state_q     <= IDLE;
         sign_q      <= 1'b0;
         mag_q       <= '0;
         exp_q       <= '0;
         result_q    <= FP9_ZERO;
         ov_q        <= 1'b0;
         z_q         <= 1'b0;
         inexact_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sign_q      <= sign_d;
         mag_q       <= mag_d;
         exp_q       <= exp_d;
         result_q    <= result_d;
         ov_q        <= ov_d;
         z_q         <= z_d;
         inexact_q   <= inexact_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = out_valid_q;
   assign out_result  = result_q;
   assign out_ov      = ov_q;
   assign out_z       = z_q;
   assign out_inexact = inexact_q;

endmodule : int_to_fp9

// File: tb/tb_int_to_fp9.sv
// Self-checking bench for int_to_fp9: directed table, handshake/reset sequences,
// and random operands against an arithmetic reference model.
module tb_int_to_fp9;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [8:0]  out_result;
   logic        out_ov;
   logic        out_z;
   logic        out_inexact;

   int n_vec = 0;
   int n_err = 0;

   int_to_fp9 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_ov      (out_ov),
      .out_z       (out_z),
      .out_inexact (out_inexact)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d;
      logic [8:0]  res;
      logic        ov;
      logic        z;
      logic        inex;
      int          lat;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
      end
   endtask

   // Value = 1.f * 2^(e-1): the leading-one position p of |x| gives e = p + 1 directly.
   function automatic void ref_model(input logic [15:0] d, output logic [8:0] res,
                                     output logic ov, output logic z, output logic inex,
                                     output int lat);
      int v, a, p, e, f;
      v = $signed(d);
      a = (v < 0) ? -v : v;
      res = '0; ov = 1'b0; z = 1'b0; inex = 1'b0; lat = 2;
      if (a >= 32768) begin
         ov  = 1'b1;
         res = {d[15], 8'hFF};
      end else if (a == 0) begin
         z = 1'b1;
      end else begin
         p = 0;
         while ((1 << (p + 1)) <= a) p++;
         e = p + 1;
         if (p >= 4) f = (a >> (p - 4)) & 15;
         else        f = (a << (4 - p)) & 15;
         inex = (p > 4) && ((a & ((1 << (p - 4)) - 1)) != 0);
         res  = {d[15], e[3:0], f[3:0]};
         lat  = 16 - p;
      end
   endfunction

   // Counts edges from the accept edge until out_valid is seen.
   task automatic wait_result(input string tag, output int lat);
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         in_data = 16'($urandom);
         tick();
         lat++;
         if (out_valid) return;
      end
      check({tag, "_timeout"}, 32'd1, 32'd0);
      lat = -1;
   endtask

   task automatic accept(input string tag, input logic [15:0] d);
      int waited;
      waited = 0;
      while (!in_ready && waited < 40) begin
         tick();
         waited++;
      end
      if (!in_ready) check({tag, "_in_ready_timeout"}, 32'd0, 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic compare_out(input string tag, input vec_t v, input int lat);
      check({tag, "_result"},  32'(out_result),  32'(v.res));
      check({tag, "_ov"},      32'(out_ov),      32'(v.ov));
      check({tag, "_z"},       32'(out_z),       32'(v.z));
      check({tag, "_inexact"}, 32'(out_inexact), 32'(v.inex));
      check({tag, "_latency"}, 32'(lat),         32'(v.lat));
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      int lat;
      accept(tag, v.d);
      wait_result(tag, lat);
      compare_out(tag, v, lat);
      tick();
   endtask

   vec_t tbl[12];
   vec_t rv;
   vec_t v100;
   vec_t v3;
   int   lat;

   initial begin
      tbl[0]  = '{16'd1,     9'h010, 1'b0, 1'b0, 1'b0, 16};
      tbl[1]  = '{16'd100,   9'h079, 1'b0, 1'b0, 1'b0, 10};
      tbl[2]  = '{16'hB1E0,  9'h1F3, 1'b0, 1'b0, 1'b1, 2};
      tbl[3]  = '{16'h8000,  9'h1FF, 1'b1, 1'b0, 1'b0, 2};
      tbl[4]  = '{16'h0000,  9'h000, 1'b0, 1'b1, 1'b0, 2};
      tbl[5]  = '{16'hFFFF,  9'h110, 1'b0, 1'b0, 1'b0, 16};
      tbl[6]  = '{16'h7FFF,  9'h0FF, 1'b0, 1'b0, 1'b1, 2};
      tbl[7]  = '{16'h8001,  9'h1FF, 1'b0, 1'b0, 1'b1, 2};
      tbl[8]  = '{16'h4000,  9'h0F0, 1'b0, 1'b0, 1'b0, 2};
      tbl[9]  = '{16'd17,    9'h051, 1'b0, 1'b0, 1'b0, 12};
      tbl[10] = '{16'd33,    9'h060, 1'b0, 1'b0, 1'b1, 11};
      tbl[11] = '{16'd3,     9'h028, 1'b0, 1'b0, 1'b0, 15};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("reset_in_ready",  32'(in_ready),    32'd1);
      check("reset_out_valid", 32'(out_valid),   32'd0);
      check("reset_result",    32'(out_result),  32'd0);
      check("reset_flags",     32'({out_ov, out_z, out_inexact}), 32'd0);

      foreach (tbl[i]) run_vec($sformatf("tbl%0d", i), tbl[i]);

      // Backpressure: hold DONE, then a one-cycle out_ready pulse with the next operand waiting.
      v100 = tbl[1];
      v3   = tbl[11];
      out_ready = 1'b0;
      accept("bp", v100.d);
      wait_result("bp", lat);
      compare_out("bp", v100, lat);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_valid",    32'(out_valid),  32'd1);
         check("bp_hold_result",   32'(out_result), 32'(v100.res));
         check("bp_hold_in_ready", 32'(in_ready),   32'd0);
      end
      in_valid  = 1'b1;
      in_data   = v3.d;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("hs_in_ready_next", 32'(in_ready),  32'd1);
      check("hs_valid_drop",    32'(out_valid), 32'd0);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_result("b2b", lat);
      compare_out("b2b", v3, lat);
      tick();

      // Reset on the fifth CONV cycle discards the conversion.
      accept("rst", 16'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_no_valid_early", 32'(out_valid), 32'd0);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rst_in_ready",  32'(in_ready),   32'd1);
      check("rst_out_valid", 32'(out_valid),  32'd0);
      check("rst_result",    32'(out_result), 32'd0);
      check("rst_flags",     32'({out_ov, out_z, out_inexact}), 32'd0);
      run_vec("after_rst", '{16'd2, 9'h020, 1'b0, 1'b0, 1'b0, 15});

      for (int i = 0; i < 200; i++) begin
         rv.d = 16'($urandom);
         if (i % 8 == 0) rv.d = 16'($urandom_range(0, 40));
         if (i % 8 == 1) rv.d = 16'(-$urandom_range(0, 40));
         ref_model(rv.d, rv.res, rv.ov, rv.z, rv.inex, rv.lat);
         run_vec($sformatf("rnd%0d_%h", i, rv.d), rv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_int_to_fp9
